// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles checksummed register-write frames from UART bytes and replies ACK/NAK
module uart_cmd_decoder #(
  parameter int          DATA_BYTES     = 4,
  parameter int          TIMEOUT_CYCLES = 120000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    received,
  input  logic [7:0]              rx_byte,
  input  logic                    recv_error,
  output logic                    transmit,
  output logic [7:0]              tx_byte,
  input  logic                    is_transmitting,
  output logic                    wr_en,
  output logic [7:0]              wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic [7:0]              err_count,
  output logic                    reply_overrun
);
  localparam int DW = 8*DATA_BYTES;
  localparam int IW = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_ADDR, S_DATA, S_CSUM} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_WAIT} tx_state_t;
  rx_state_t     r_state, w_state_nx;
  tx_state_t     r_tx, w_tx_nx;
  logic [7:0]    r_addr, r_acc, r_slot, r_tx_byte, r_err, r_wr_addr;
  logic [DW-1:0] r_data, r_wr_data;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_timer;
  logic          r_slot_full, r_wr_en, r_overrun;
  logic          w_timeout, w_wr, w_queue, w_err, w_launch, w_last;
  logic [7:0]    w_qbyte;
  assign transmit      = r_tx == T_REQ;
  assign tx_byte       = r_tx_byte;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign err_count     = r_err;
  assign reply_overrun = r_overrun;
  // Rx frame sequencing: framing errors beat bytes, bytes beat an expiring timer
  always_comb begin
    w_state_nx = r_state;
    w_wr       = 1'b0;
    w_queue    = 1'b0;
    w_qbyte    = ACK_BYTE;
    w_err      = 1'b0;
    w_last     = r_idx == IW'(DATA_BYTES - 1);
    w_timeout  = r_state != S_ADDR && r_timer == '0 && !received;
    if (recv_error) begin
      w_err      = 1'b1;
      w_state_nx = S_ADDR;
      w_queue    = r_state != S_ADDR;
      w_qbyte    = NAK_BYTE;
    end else if (received) begin
      case (r_state)
        S_ADDR: w_state_nx = S_DATA;
        S_DATA: w_state_nx = w_last ? S_CSUM : S_DATA;
        default: begin
          w_state_nx = S_ADDR;
          w_queue    = 1'b1;
          w_wr       = rx_byte == r_acc;
          w_qbyte    = w_wr ? ACK_BYTE : NAK_BYTE;
          w_err      = !w_wr;
        end
      endcase
    end else if (w_timeout) begin
      w_err      = 1'b1;
      w_state_nx = S_ADDR;
    end
  end
  // Tx handshake: launch only from idle so transmit always drops between characters
  always_comb begin
    w_tx_nx  = r_tx;
    w_launch = 1'b0;
    case (r_tx)
      T_IDLE: if (r_slot_full && !is_transmitting) begin
        w_launch = 1'b1;
        w_tx_nx  = T_REQ;
      end
      T_REQ:   w_tx_nx = is_transmitting ? T_WAIT : T_REQ;
      default: w_tx_nx = is_transmitting ? T_WAIT : T_IDLE;
    endcase
  end
  // State registers for both FSMs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ADDR;
      r_tx    <= T_IDLE;
    end else begin
      r_state <= w_state_nx;
      r_tx    <= w_tx_nx;
    end
  end
  // Frame datapath, timer, error counter and the one-deep reply slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_acc       <= '0;
      r_data      <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_err       <= '0;
      r_slot      <= '0;
      r_slot_full <= 1'b0;
      r_overrun   <= 1'b0;
      r_tx_byte   <= '0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_addr;
        r_wr_data <= r_data;
      end
      if (received && !recv_error && r_state == S_ADDR) begin
        r_addr <= rx_byte;
        r_acc  <= rx_byte;
        r_idx  <= '0;
      end
      if (received && !recv_error && r_state == S_DATA) begin
        r_data[8*r_idx +: 8] <= rx_byte;
        r_acc                <= r_acc ^ rx_byte;
        r_idx                <= r_idx + 1'b1;
      end
      if (received) r_timer <= TW'(TIMEOUT_CYCLES);
      else if (r_timer != '0) r_timer <= r_timer - 1'b1;
      if (w_err && r_err != 8'hFF) r_err <= r_err + 1'b1;
      if (w_queue) begin
        r_slot      <= w_qbyte;
        r_slot_full <= 1'b1;
        if (r_slot_full && !w_launch) r_overrun <= 1'b1;
      end else if (w_launch) r_slot_full <= 1'b0;
      if (w_launch) r_tx_byte <= r_slot;
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed frame vectors plus multi-cycle corner sequences
module tb_uart_cmd_decoder;
  localparam int TO = 40;
  typedef struct packed {
    logic [47:0] f;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [7:0]  tx;
    logic        nak;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst, received, recv_error, is_transmitting;
  logic [7:0]  rx_byte;
  logic        transmit, wr_en, reply_overrun;
  logic [7:0]  tx_byte, wr_addr, err_count;
  logic [31:0] wr_data;
  int          n_vec = 0, n_bad = 0;
  int          cyc = 0, wr_cnt = 0, tx_cnt = 0, wr_cyc = 0, tx_cyc = 0, tx_glitch = 0;
  int          strobe_cyc = 0, busy = 0, exp_err = 0;
  logic [7:0]  last_tx = 8'h00;
  logic        prev_tx = 1'b0, hold = 1'b0, noack = 1'b0;
  vec_t        vecs[7];

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte), .recv_error(recv_error),
    .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err_count(err_count),
    .reply_overrun(reply_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_tx <= transmit;
    if (wr_en) begin
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
    end
    if (transmit && !prev_tx) begin
      tx_cnt  <= tx_cnt + 1;
      tx_cyc  <= cyc;
      last_tx <= tx_byte;
    end
    if (transmit && prev_tx && tx_byte != last_tx) tx_glitch <= tx_glitch + 1;
  end

  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (noack) is_transmitting = 1'b0;
      else if (hold) is_transmitting = 1'b1;
      else if (busy > 0) begin
        busy--;
        is_transmitting = busy != 0;
      end else if (transmit) begin
        is_transmitting = 1'b1;
        busy = 4;
      end else is_transmitting = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 received = 1'b1;
    rx_byte = b;
    strobe_cyc = cyc;
    @(posedge clk);
    #1 received = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input int gap);
    for (int i = 0; i < 6; i++) begin
      send_byte(f[47-8*i -: 8]);
      if (i < 5) repeat (gap) @(posedge clk);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w0, t0, sc;
    vecs[0] = '{48'h12EFBEADDE30, 1'b1, 8'h12, 32'hDEADBEEF, 8'h06, 1'b0};
    vecs[1] = '{48'h12EFBEADDE31, 1'b0, 8'h12, 32'hDEADBEEF, 8'h15, 1'b1};
    vecs[2] = '{48'h340100000035, 1'b1, 8'h34, 32'h00000001, 8'h06, 1'b0};
    vecs[3] = '{48'hA500000000A5, 1'b1, 8'hA5, 32'h00000000, 8'h06, 1'b0};
    vecs[4] = '{48'hFF11223344BB, 1'b1, 8'hFF, 32'h44332211, 8'h06, 1'b0};
    vecs[5] = '{48'h000102030405, 1'b0, 8'hFF, 32'h44332211, 8'h15, 1'b1};
    vecs[6] = '{48'h807856341288, 1'b1, 8'h80, 32'h12345678, 8'h06, 1'b0};
    rst = 1'b1; received = 1'b0; recv_error = 1'b0; rx_byte = 8'h00;
    settle(3);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_overrun", reply_overrun, 0);
    rst = 1'b0;
    settle(2);
    for (int v = 0; v < 7; v++) begin
      w0 = wr_cnt; t0 = tx_cnt;
      send_frame(vecs[v].f, 0);
      sc = strobe_cyc;
      settle(15);
      exp_err += int'(vecs[v].nak);
      chk($sformatf("v%0d_wr_count", v), wr_cnt - w0, {31'd0, vecs[v].wr});
      chk($sformatf("v%0d_wr_addr", v), wr_addr, vecs[v].a);
      chk($sformatf("v%0d_wr_data", v), wr_data, vecs[v].d);
      chk($sformatf("v%0d_tx_count", v), tx_cnt - t0, 1);
      chk($sformatf("v%0d_tx_byte", v), last_tx, vecs[v].tx);
      chk($sformatf("v%0d_tx_latency", v), tx_cyc - sc, 2);
      if (vecs[v].wr) chk($sformatf("v%0d_wr_latency", v), wr_cyc - sc, 1);
      chk($sformatf("v%0d_err_count", v), err_count, exp_err);
    end
    w0 = wr_cnt; t0 = tx_cnt;
    send_frame(48'h12EFBEADDE30, TO - 1);
    settle(15);
    chk("gap_max_wr_count", wr_cnt - w0, 1);
    chk("gap_max_err", err_count, exp_err);
    w0 = wr_cnt; t0 = tx_cnt;
    send_frame(48'h12EFBEADDE30, TO);
    settle(TO + 5);
    exp_err += 6;
    chk("gap_over_wr_count", wr_cnt - w0, 0);
    chk("gap_over_tx_count", tx_cnt - t0, 0);
    chk("gap_over_err", err_count, exp_err);
    t0 = tx_cnt;
    send_byte(8'h12); send_byte(8'hEF); send_byte(8'hBE);
    settle(TO + 5);
    exp_err++;
    chk("timeout_err", err_count, exp_err);
    chk("timeout_silent", tx_cnt - t0, 0);
    w0 = wr_cnt; t0 = tx_cnt;
    send_frame(48'h340100000035, 0);
    settle(15);
    chk("timeout_next_wr", wr_cnt - w0, 1);
    chk("timeout_next_addr", wr_addr, 8'h34);
    chk("timeout_next_data", wr_data, 32'h00000001);
    chk("timeout_next_tx", tx_cnt - t0, 1);
    chk("timeout_next_ack", last_tx, 8'h06);
    t0 = tx_cnt;
    send_byte(8'h12); send_byte(8'hEF);
    @(posedge clk); #1 recv_error = 1'b1;
    @(posedge clk); #1 recv_error = 1'b0;
    settle(15);
    exp_err++;
    chk("rxerr_tx_count", tx_cnt - t0, 1);
    chk("rxerr_nak", last_tx, 8'h15);
    chk("rxerr_err", err_count, exp_err);
    w0 = wr_cnt;
    send_frame(48'h807856341288, 0);
    settle(15);
    chk("rxerr_next_wr", wr_cnt - w0, 1);
    chk("rxerr_next_ack", last_tx, 8'h06);
    t0 = tx_cnt;
    @(posedge clk); #1 recv_error = 1'b1;
    @(posedge clk); #1 recv_error = 1'b0;
    settle(10);
    exp_err++;
    chk("idle_rxerr_err", err_count, exp_err);
    chk("idle_rxerr_silent", tx_cnt - t0, 0);
    chk("overrun_before", reply_overrun, 0);
    hold = 1'b1;
    settle(2);
    w0 = wr_cnt; t0 = tx_cnt;
    send_frame(48'h340100000035, 0);
    send_frame(48'hA500000000A5, 0);
    settle(10);
    chk("overrun_wr_count", wr_cnt - w0, 2);
    chk("overrun_held_tx", tx_cnt - t0, 0);
    chk("overrun_flag", reply_overrun, 1);
    hold = 1'b0;
    settle(20);
    chk("overrun_one_tx", tx_cnt - t0, 1);
    chk("overrun_ack", last_tx, 8'h06);
    chk("overrun_sticky", reply_overrun, 1);
    chk("tx_byte_stable", tx_glitch, 0);
    noack = 1'b1;
    send_frame(48'h12EFBEADDE30, 0);
    for (int i = 0; i < 20; i++) begin
      if (transmit) break;
      settle(1);
    end
    chk("treq_reached", transmit, 1);
    rst = 1'b1;
    settle(1);
    chk("rst_treq_transmit", transmit, 0);
    chk("rst_treq_wr_en", wr_en, 0);
    chk("rst_treq_wr_addr", wr_addr, 0);
    chk("rst_treq_wr_data", wr_data, 0);
    chk("rst_treq_tx_byte", tx_byte, 0);
    chk("rst_treq_err", err_count, 0);
    chk("rst_treq_overrun", reply_overrun, 0);
    rst = 1'b0; noack = 1'b0;
    w0 = wr_cnt; t0 = tx_cnt;
    settle(15);
    chk("rst_treq_no_wr", wr_cnt - w0, 0);
    chk("rst_treq_no_tx", tx_cnt - t0, 0);
    @(posedge clk); #1 recv_error = 1'b1;
    repeat (260) @(posedge clk);
    #1 recv_error = 1'b0;
    settle(2);
    chk("err_saturate", err_count, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
